// File: rtl/branch_controller_pkg.sv
// Shared definitions for the branch controller.
//   - br_op encodings (BR_JZ, BR_JN, BR_JC, BR_JMP)
//   - flag bit indices into the CCR (FLAG_Z, FLAG_N, FLAG_C)
//   - FSM state type
package branch_controller_pkg;

  localparam logic [1:0] BR_JZ  = 2'b00;
  localparam logic [1:0] BR_JN  = 2'b01;
  localparam logic [1:0] BR_JC  = 2'b10;
  localparam logic [1:0] BR_JMP = 2'b11;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

  typedef enum logic {
    StIdle,
    StFlush
  } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   eff_flags  in  3  flags as seen by the branch (already bypassed)
//   br_op      in  2  branch type
//   taken      out 1  branch condition holds
//   next_flags out 3  eff_flags with the tested bit cleared (JMP leaves them untouched)
module branch_cond_eval
  import branch_controller_pkg::*;
(
  input  logic [2:0] eff_flags,
  input  logic [1:0] br_op,
  output logic       taken,
  output logic [2:0] next_flags
);

  always_comb begin
    taken      = 1'b0;
    next_flags = eff_flags;
    unique case (br_op)
      BR_JZ: begin
        taken              = eff_flags[FLAG_Z];
        next_flags[FLAG_Z] = 1'b0;
      end
      BR_JN: begin
        taken              = eff_flags[FLAG_N];
        next_flags[FLAG_N] = 1'b0;
      end
      BR_JC: begin
        taken              = eff_flags[FLAG_C];
        next_flags[FLAG_C] = 1'b0;
      end
      BR_JMP: begin
        taken = 1'b1;
      end
      default: begin
        taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_controller.sv
// Branch controller: owns the flag register (CCR), resolves branches in the
// cycle they are presented, and issues a one-cycle redirect plus a multi-cycle
// fetch/decode flush for taken branches.
// Ports:
//   clk            in  1     clock, rising edge
//   rst_n          in  1     asynchronous active-low reset
//   alu_flag_we    in  1     ALU flag write strobe
//   alu_flags      in  3     ALU flags {C, N, Z}
//   br_valid       in  1     branch presented this cycle
//   br_op          in  2     00 JZ, 01 JN, 10 JC, 11 JMP
//   br_target      in  PC_W  branch destination
//   flags          out 3     architectural flag register
//   redirect_valid out 1     one-cycle PC load request
//   redirect_pc    out PC_W  PC to load (holds last value)
//   flush          out 1     squash fetch/decode
//   taken_cnt      out 8     saturating taken-branch count
module branch_controller
  import branch_controller_pkg::*;
#(
  parameter int unsigned PC_W         = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_flag_we,
  input  logic [2:0]      alu_flags,
  input  logic            br_valid,
  input  logic [1:0]      br_op,
  input  logic [PC_W-1:0] br_target,
  output logic [2:0]      flags,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [7:0]      taken_cnt
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  br_state_e       state_q;
  logic [2:0]      cnt_q;
  logic [2:0]      flags_q;
  logic            redirect_valid_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic            flush_q;
  logic [7:0]      taken_cnt_q;

  logic [2:0]      eff_flags;
  logic            taken;
  logic [2:0]      next_flags;

  // Same-cycle bypass so a branch sees the flags its producer is writing now.
  assign eff_flags = alu_flag_we ? alu_flags : flags_q;

  branch_cond_eval u_cond_eval (
    .eff_flags  (eff_flags),
    .br_op      (br_op),
    .taken      (taken),
    .next_flags (next_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      cnt_q            <= 3'd0;
      flags_q          <= 3'b000;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      taken_cnt_q      <= 8'd0;
    end else begin
      redirect_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (br_valid) begin
            // Branch clear wins over a plain ALU write; next_flags already
            // carries the bypassed ALU value for the untested bits.
            flags_q <= next_flags;
            if (taken) begin
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= br_target;
              flush_q          <= 1'b1;
              cnt_q            <= FlushLoad;
              state_q          <= StFlush;
              if (taken_cnt_q != 8'hFF) begin
                taken_cnt_q <= taken_cnt_q + 8'd1;
              end
            end
          end else if (alu_flag_we) begin
            flags_q <= alu_flags;
          end
        end
        StFlush: begin
          // Wrong-path branches are ignored; ALU writes still land.
          if (alu_flag_we) begin
            flags_q <= alu_flags;
          end
          if (cnt_q == 3'd0) begin
            flush_q <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign flags          = flags_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: doc/branch_controller.md
BRANCH_CONTROLLER -- requirements
Module: branch_controller

Interface
REQ-001 Parameter PC_W, default 16, SHALL set the program-counter / branch-target width.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1..7, SHALL set the number of cycles `flush` is held after a taken branch.
REQ-003 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port alu_flag_we  in  1  SHALL be the ALU flag write strobe.
REQ-006 Port alu_flags  in  3  SHALL carry the ALU result flags: bit0 Z, bit1 N, bit2 C.
REQ-007 Port br_valid  in  1  SHALL mark a branch instruction presented this cycle.
REQ-008 Port br_op  in  2  SHALL encode the branch type: 00 JZ, 01 JN, 10 JC, 11 JMP (unconditional).
REQ-009 Port br_target  in  PC_W  SHALL carry the branch destination.
REQ-010 Port flags  out  3  SHALL expose the architectural flag register (CCR).
REQ-011 Port redirect_valid  out  1  SHALL be a one-cycle pulse requesting a PC load.
REQ-012 Port redirect_pc  out  PC_W  SHALL carry the PC to load, valid while redirect_valid=1.
REQ-013 Port flush  out  1  SHALL request squash of the fetch/decode stages.
REQ-014 Port taken_cnt  out  8  SHALL count taken branches, saturating at 255.

Function
REQ-015 The FSM SHALL have two states: IDLE and FLUSH.
REQ-016 IDLE: when br_valid=1, the branch SHALL be evaluated in the same cycle using the effective flags.
- Effective flags are alu_flags when alu_flag_we=1 (bypass), else the `flags` register.
REQ-017 Taken condition:
- JZ is taken iff effective Z=1.
- JN is taken iff effective N=1.
- JC is taken iff effective C=1.
- JMP is always taken.
REQ-018 An evaluated JZ/JN/JC SHALL clear its tested flag bit in the next-cycle `flags`, whether taken or not; the other two bits SHALL keep their effective values.
- JMP SHALL NOT modify the flags.
REQ-019 Flag register update priority: branch clear over alu_flag_we write over hold; alu_flag_we alone SHALL load alu_flags.
REQ-020 On a taken branch:
- redirect_valid and redirect_pc=br_target SHALL be registered, asserting in the next cycle for exactly one cycle.
- flush SHALL assert in that same cycle.
- The FSM SHALL enter FLUSH with its down-counter loaded to FLUSH_CYCLES-1.
REQ-021 FLUSH: flush SHALL stay 1; the counter SHALL decrement each cycle; the FSM SHALL return to IDLE the cycle after the counter reads 0. Total flush high time = FLUSH_CYCLES cycles.
REQ-022 In FLUSH, br_valid SHALL be ignored (wrong-path instruction): no evaluation, no flag clear, no count; alu_flag_we SHALL still update `flags`.
REQ-023 A not-taken branch SHALL produce no redirect_valid and no flush, and the FSM SHALL stay in IDLE.
REQ-024 taken_cnt SHALL increment by 1 per taken branch and hold at 255.
REQ-025 redirect_pc SHALL hold its last value when redirect_valid=0.
REQ-026 br_op values outside the listed encodings do not exist (2-bit field fully decoded); br_valid=0 SHALL cause no action regardless of br_op.

Reset
REQ-027 rst_n=0 SHALL immediately force:
- flags=000, redirect_valid=0, redirect_pc=0, flush=0, taken_cnt=0
- FSM to IDLE, counter to 0
This holds even mid-FLUSH; the pending flush SHALL be abandoned.
REQ-028 The first edge after rst_n deasserts SHALL behave as IDLE with cleared flags.

Structure
REQ-029 A shared package SHALL hold:
- the br_op encodings (BR_JZ, BR_JN, BR_JC, BR_JMP)
- the flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2)
- the FSM state typedef
REQ-030 One sub-module, branch_cond_eval (combinational: effective flags, br_op -> taken, next flags), SHALL be instantiated once.

Verification
REQ-031 Bench SHALL cover:
- Reset then flags=000; JZ at target 0x0040 -> not taken, no flush, flags stay 000.
- alu_flag_we=1 with alu_flags=011 in the same cycle as JZ at target 0x0100 -> next cycle redirect_valid=1, redirect_pc=0x0100; flush high 2 cycles; flags=010.
- JMP at 0x0200 followed by br_valid JC on each of the next 2 cycles with C=1 -> only one redirect; C stays 1; taken_cnt +1.
- JN with N=1 and simultaneous alu_flag_we alu_flags=000 -> not taken (bypass); flags=000.
- rst_n pulsed low during the 2nd flush cycle -> flush=0 asynchronously; IDLE; taken_cnt=0.
- 256 taken JMPs -> taken_cnt saturates at 255.
